// File: rtl/axi_line_master.sv
`timescale 1ns/1ps
// AXI4 cache-line master: one refill (AR/R) or writeback (AW/W/B) burst at a time.
// Define AXI_LINE_MASTER_ERR_CHK_EN to latch protocol/response errors onto rsp_err.
module axi_line_master #(
   parameter int unsigned ADDR_WTH   = 32,
   parameter int unsigned DATA_WTH   = 256,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned LINE_BEATS = 2,
   parameter int unsigned AXI_ID     = 0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   // line request / completion
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_we,
   input  logic [ADDR_WTH-1:0]            req_addr,
   input  logic [LINE_BEATS*DATA_WTH-1:0] req_wdata,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [LINE_BEATS*DATA_WTH-1:0] rsp_rdata,
   output logic                           rsp_err,
   // AR
   output logic [ADDR_WTH-1:0]            araddr,
   output logic [7:0]                     arlen,
   output logic [2:0]                     arsize,
   output logic [1:0]                     arburst,
   output logic [ID_WIDTH-1:0]            arid,
   output logic [3:0]                     arcache,
   output logic                           arlock,
   output logic [2:0]                     arprot,
   output logic [3:0]                     arqos,
   output logic [3:0]                     arregion,
   output logic                           arvalid,
   input  logic                           arready,
   // R
   input  logic [DATA_WTH-1:0]            rdata,
   input  logic [1:0]                     rresp,
   input  logic [ID_WIDTH-1:0]            rid,
   input  logic                           rlast,
   input  logic                           rvalid,
   output logic                           rready,
   // AW
   output logic [ADDR_WTH-1:0]            awaddr,
   output logic [7:0]                     awlen,
   output logic [2:0]                     awsize,
   output logic [1:0]                     awburst,
   output logic [ID_WIDTH-1:0]            awid,
   output logic [3:0]                     awcache,
   output logic                           awlock,
   output logic [2:0]                     awprot,
   output logic [3:0]                     awqos,
   output logic [3:0]                     awregion,
   output logic                           awvalid,
   input  logic                           awready,
   // W
   output logic [DATA_WTH-1:0]            wdata,
   output logic [DATA_WTH/8-1:0]          wstrb,
   output logic                           wlast,
   output logic                           wvalid,
   input  logic                           wready,
   // B
   input  logic [1:0]                     bresp,
   input  logic [ID_WIDTH-1:0]            bid,
   input  logic                           bvalid,
   output logic                           bready
);

   localparam int unsigned OFF_W = $clog2(LINE_BEATS * DATA_WTH / 8);
   localparam int unsigned IDX_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0]    LB_C   = CNT_W'(LINE_BEATS);
   localparam logic [CNT_W-1:0]    LAST_C = CNT_W'(LINE_BEATS - 1);
   localparam logic [2:0]          SIZE_C = 3'($clog2(DATA_WTH / 8));
   localparam logic [ID_WIDTH-1:0] ID_C   = ID_WIDTH'(AXI_ID);

   typedef enum logic [2:0] {
      ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B, ST_RSP
   } state_e;

   state_e                               state_q, state_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic [ADDR_WTH-1:0]                  addr_q;
   logic [LINE_BEATS-1:0][DATA_WTH-1:0]  wline_q;
   logic [LINE_BEATS-1:0][DATA_WTH-1:0]  rline_q;

   logic accept, r_hs, w_hs, r_store;

   assign accept  = (state_q == ST_IDLE) && req_valid;
   assign r_hs    = (state_q == ST_R) && rvalid;
   assign w_hs    = (state_q == ST_W) && wready;
   assign r_store = r_hs && (cnt_q < LB_C);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_valid)           state_d = req_we ? ST_AW : ST_AR;
         ST_AR:   if (arready)             state_d = ST_R;
         ST_R:    if (rvalid && rlast)     state_d = ST_RSP;
         ST_AW:   if (awready)             state_d = ST_W;
         ST_W:    if (wready && cnt_q == LAST_C) state_d = ST_B;
         ST_B:    if (bvalid)              state_d = ST_RSP;
         ST_RSP:  if (rsp_ready)           state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // Refill counter saturates at LINE_BEATS so surplus beats stay out of the buffer.
   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if (r_store) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (w_hs) begin
         cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= {req_addr[ADDR_WTH-1:OFF_W], {OFF_W{1'b0}}};
            wline_q <= req_wdata;
         end
         if (r_store) begin
            rline_q[cnt_q[IDX_W-1:0]] <= rdata;
         end
      end
   end

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[OFF_W-1:0];

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_rdata = rline_q;

   assign araddr   = addr_q;
   assign arlen    = 8'(LINE_BEATS - 1);
   assign arsize   = SIZE_C;
   assign arburst  = 2'b01;
   assign arid     = ID_C;
   assign arcache  = '0;
   assign arlock   = 1'b0;
   assign arprot   = '0;
   assign arqos    = '0;
   assign arregion = '0;
   assign arvalid  = (state_q == ST_AR);
   assign rready   = (state_q == ST_R);

   assign awaddr   = addr_q;
   assign awlen    = 8'(LINE_BEATS - 1);
   assign awsize   = SIZE_C;
   assign awburst  = 2'b01;
   assign awid     = ID_C;
   assign awcache  = '0;
   assign awlock   = 1'b0;
   assign awprot   = '0;
   assign awqos    = '0;
   assign awregion = '0;
   assign awvalid  = (state_q == ST_AW);

   assign wvalid = (state_q == ST_W);
   assign wdata  = wline_q[cnt_q[IDX_W-1:0]];
   assign wstrb  = '1;
   assign wlast  = (cnt_q == LAST_C);
   assign bready = (state_q == ST_B);

`ifdef AXI_LINE_MASTER_ERR_CHK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = 1'b0;
      end else if (r_hs && ((rresp != '0) || (rid != ID_C) ||
                            (rlast && cnt_q != LAST_C) || (cnt_q >= LB_C))) begin
         err_d = 1'b1;
      end else if ((state_q == ST_B) && bvalid && ((bresp != '0) || (bid != ID_C))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign rsp_err = err_q;
`else
   logic unused_chk;
   assign unused_chk = ^{rresp, rid, bresp, bid};
   assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_line_master.sv
`timescale 1ns/1ps
// Self-checking bench for axi_line_master: randomized AXI slave plus a line-level reference model.
module tb_axi_line_master;
   localparam int unsigned DW   = 256;
   localparam int unsigned IDW  = 4;
   localparam int unsigned LB   = 2;
   localparam int unsigned AXID = 3;
   localparam int unsigned LW   = LB * DW;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic req_valid, req_ready, req_we;
   logic [31:0] req_addr;
   logic [LW-1:0] req_wdata, rsp_rdata;
   logic rsp_valid, rsp_ready, rsp_err;
   logic [31:0] araddr, awaddr;
   logic [7:0] arlen, awlen;
   logic [2:0] arsize, awsize, arprot, awprot;
   logic [1:0] arburst, awburst, rresp, bresp;
   logic [IDW-1:0] arid, awid, rid, bid;
   logic [3:0] arcache, arqos, arregion, awcache, awqos, awregion;
   logic arlock, awlock, arvalid, arready, awvalid, awready;
   logic [DW-1:0] rdata, wdata;
   logic [DW/8-1:0] wstrb;
   logic rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

   axi_line_master #(.ADDR_WTH(32), .DATA_WTH(DW), .ID_WIDTH(IDW), .LINE_BEATS(LB), .AXI_ID(AXID)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid), .arcache(arcache),
      .arlock(arlock), .arprot(arprot), .arqos(arqos), .arregion(arregion), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid), .awcache(awcache),
      .awlock(awlock), .awprot(awprot), .awqos(awqos), .awregion(awregion), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // reference model: refill buffer contents and expected error flag
   logic [LW-1:0] exp_line = '0;
   bit            exp_err = 1'b0;

   // observations from the last transaction
   logic [31:0] o_addr;
   logic [7:0]  o_len;
   logic [2:0]  o_size;
   logic [1:0]  o_burst;
   logic [IDW-1:0] o_id;
   logic [15:0] o_misc;
   int o_ax_hs, o_vcyc, o_unstable, o_wrong, o_wdata_bad, o_wstrb_bad, o_w_early, o_b_hs;
   int o_rsp_unstable, o_req_ready_bad, o_rsp_cyc;
   logic [DW-1:0] o_wbeats[$];
   bit o_wlast[$];
   logic [LW-1:0] o_rdata;
   logic o_err;
   bit o_timeout, o_b2b_ok, o_first_ok;

   function automatic logic [DW-1:0] rnd_beat();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [31:0] line_base(input logic [31:0] a);
      return a & ~(32'(LW / 8) - 32'd1);
   endfunction

   // Acts as the AXI slave for one request and records what the master did.
   task automatic run_txn(input bit we, input logic [31:0] addr, input logic [LW-1:0] wline,
                          input logic [DW-1:0] rb [16], input int nbeats, input int bad_beat,
                          input int ax_stall, input int wmod, input int rsp_stall, input bit bbad);
      int r_idx = 0, w_idx = 0, vcyc = 0, rcyc = 0, n = 0;
      bit ax_done = 0, ax_top, w_top, b_done = 0, fin = 0, ax_v;
      logic [31:0] ax_a;
      o_ax_hs = 0; o_unstable = 0; o_wrong = 0; o_wdata_bad = 0; o_wstrb_bad = 0; o_w_early = 0;
      o_b_hs = 0; o_rsp_unstable = 0; o_req_ready_bad = 0; o_timeout = 0; o_b2b_ok = 0; o_first_ok = 0;
      o_wbeats.delete(); o_wlast.delete();
      @(negedge clk_i);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wline;
      while (!req_ready && n < 50) begin @(negedge clk_i); n++; end
      if (!req_ready) o_timeout = 1;
      @(negedge clk_i);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = {16{32'($urandom)}};
      if (o_timeout) return;
      o_first_ok = we ? (awvalid && !arvalid) : (arvalid && !awvalid);
      n = 0;
      while (!fin && n < 400) begin
         ax_top = ax_done;
         w_top  = (w_idx >= int'(LB));
         ax_v = we ? awvalid : arvalid;
         ax_a = we ? awaddr : araddr;
         if (we ? arvalid : awvalid) o_wrong++;
         arready = 1'b0; awready = 1'b0;
         if (ax_v) begin
            vcyc++;
            if (vcyc == 1) begin
               o_addr = ax_a;
               o_len = we ? awlen : arlen;
               o_size = we ? awsize : arsize;
               o_burst = we ? awburst : arburst;
               o_id = we ? awid : arid;
               o_misc = we ? {awcache, awlock, awprot, awqos, awregion} : {arcache, arlock, arprot, arqos, arregion};
            end else if (ax_a !== o_addr) o_unstable++;
            if (!ax_done && vcyc > ax_stall) begin
               if (we) awready = 1'b1; else arready = 1'b1;
               o_ax_hs++;
               ax_done = 1;
            end
         end
         rvalid = 1'b0;
         if (!we && ax_top && r_idx < nbeats && $urandom_range(0, 3) != 0) begin
            rvalid = 1'b1; rdata = rb[r_idx]; rid = IDW'(AXID);
            rresp = (r_idx == bad_beat) ? 2'd2 : 2'd0;
            rlast = (r_idx == nbeats - 1);
            if (rready) r_idx++;
         end
         wready = (cyc % wmod == 0);
         if (wvalid) begin
            if (!ax_top) o_w_early++;
            if (w_idx >= int'(LB) || wdata !== wline[w_idx*DW +: DW]) o_wdata_bad++;
            if (wstrb !== '1) o_wstrb_bad++;
            if (wready) begin o_wbeats.push_back(wdata); o_wlast.push_back(wlast); w_idx++; end
         end
         bvalid = 1'b0;
         if (we && w_top && !b_done) begin
            bvalid = 1'b1; bresp = bbad ? 2'd2 : 2'd0; bid = IDW'(AXID);
            if (bready) begin o_b_hs++; b_done = 1; end
         end
         rsp_ready = 1'b0;
         if (rsp_valid) begin
            rcyc++;
            if (rcyc == 1) begin o_rdata = rsp_rdata; o_err = rsp_err; end
            else if (rsp_rdata !== o_rdata || rsp_err !== o_err) o_rsp_unstable++;
            if (rcyc > rsp_stall) begin rsp_ready = 1'b1; fin = 1; end
         end
         if (req_ready) o_req_ready_bad++;
         cyc++; n++;
         @(negedge clk_i);
      end
      arready = 0; awready = 0; rvalid = 0; wready = 0; bvalid = 0; rsp_ready = 0;
      o_timeout = !fin; o_vcyc = vcyc; o_rsp_cyc = rcyc;
      o_b2b_ok = req_ready && !rsp_valid;
      if (!we)
         for (int i = 0; i < nbeats && i < int'(LB); i++) exp_line[i*DW +: DW] = rb[i];
`ifdef AXI_LINE_MASTER_ERR_CHK_EN
      exp_err = we ? bbad : ((bad_beat >= 0 && bad_beat < nbeats) || nbeats != int'(LB));
`else
      exp_err = 1'b0;
`endif
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      #1 rst_i = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if ({arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err} !== 7'b0) begin failures++;
         $display("FAIL reset_valids got=%b exp=0000000", {arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err}); end
      checks++; if (rsp_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
      checks++; if (araddr !== 32'h0 || awaddr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h/%h exp=0", araddr, awaddr); end
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      exp_line = '0; exp_err = 1'b0;
   endtask

   task automatic test_refill();
      logic [DW-1:0] rb [16];
      logic [LW-1:0] lit;
      foreach (rb[i]) rb[i] = rnd_beat();
      rb[0] = {8{32'hAAAA_AAAA}};
      rb[1] = {8{32'hBBBB_BBBB}};
      lit = {rb[1], rb[0]};
      run_txn(0, 32'h8000_0044, '0, rb, 2, -1, 0, 1, 0, 0);
      checks++; if (o_timeout) begin failures++; $display("FAIL refill_timeout got=1 exp=0"); end
      checks++; if (!o_first_ok) begin failures++; $display("FAIL refill_arvalid_next_cycle got=0 exp=1"); end
      checks++; if (o_addr !== 32'h8000_0040) begin failures++; $display("FAIL refill_araddr got=%h exp=80000040", o_addr); end
      checks++; if ({o_len, o_size, o_burst} !== {8'd1, 3'd5, 2'd1}) begin failures++;
         $display("FAIL refill_len_size_burst got=%0d/%0d/%0d exp=1/5/1", o_len, o_size, o_burst); end
      checks++; if (o_id !== IDW'(AXID) || o_misc !== 16'h0) begin failures++;
         $display("FAIL refill_id_misc got=%h/%h exp=%h/0", o_id, o_misc, IDW'(AXID)); end
      checks++; if (o_rdata !== lit) begin failures++; $display("FAIL refill_rdata got=%h exp=%h", o_rdata, lit); end
      checks++; if (o_err !== exp_err) begin failures++; $display("FAIL refill_err got=%b exp=%b", o_err, exp_err); end
   endtask

   task automatic test_writeback();
      logic [DW-1:0] rb [16];
      logic [LW-1:0] line;
      foreach (rb[i]) rb[i] = '0;
      line = {{8{32'h2222_2222}}, {8{32'h1111_1111}}};
      run_txn(1, 32'h8020_0000, line, rb, 0, -1, 0, 4, 0, 0);
      checks++; if (o_timeout) begin failures++; $display("FAIL wb_timeout got=1 exp=0"); end
      checks++; if (!o_first_ok || o_wrong != 0) begin failures++; $display("FAIL wb_awvalid_only got=%b/%0d exp=1/0", o_first_ok, o_wrong); end
      checks++; if (o_addr !== 32'h8020_0000 || o_len !== 8'd1 || o_size !== 3'd5) begin failures++;
         $display("FAIL wb_aw_fields got=%h/%0d/%0d exp=80200000/1/5", o_addr, o_len, o_size); end
      checks++; if (o_wbeats.size() != 2) begin failures++; $display("FAIL wb_beat_count got=%0d exp=2", o_wbeats.size()); end
      for (int i = 0; i < o_wbeats.size() && i < 2; i++) begin
         checks++; if (o_wbeats[i] !== line[i*DW +: DW] || o_wlast[i] !== (i == 1)) begin failures++;
            $display("FAIL wb_beat%0d got=%h last=%b exp=%h last=%b", i, o_wbeats[i], o_wlast[i], line[i*DW +: DW], (i == 1)); end
      end
      checks++; if (o_wstrb_bad != 0 || o_w_early != 0 || o_wdata_bad != 0) begin failures++;
         $display("FAIL wb_w_channel got=strb%0d/early%0d/data%0d exp=0/0/0", o_wstrb_bad, o_w_early, o_wdata_bad); end
      checks++; if (o_b_hs != 1) begin failures++; $display("FAIL wb_b_handshakes got=%0d exp=1", o_b_hs); end
      checks++; if (o_rdata !== exp_line) begin failures++; $display("FAIL wb_rdata_unchanged got=%h exp=%h", o_rdata, exp_line); end
      checks++; if (o_err !== exp_err) begin failures++; $display("FAIL wb_err got=%b exp=%b", o_err, exp_err); end
   endtask

   task automatic test_ar_stall();
      logic [DW-1:0] rb [16];
      foreach (rb[i]) rb[i] = rnd_beat();
      run_txn(0, $urandom, '0, rb, 2, -1, 5, 1, 0, 0);
      checks++; if (o_vcyc != 6 || o_unstable != 0) begin failures++;
         $display("FAIL ar_stall_hold got=cycles%0d/unstable%0d exp=6/0", o_vcyc, o_unstable); end
      checks++; if (o_ax_hs != 1) begin failures++; $display("FAIL ar_stall_handshakes got=%0d exp=1", o_ax_hs); end
      checks++; if (o_rdata !== exp_line) begin failures++; $display("FAIL ar_stall_rdata got=%h exp=%h", o_rdata, exp_line); end
   endtask

   task automatic test_rsp_backpressure();
      logic [DW-1:0] rb [16];
      foreach (rb[i]) rb[i] = rnd_beat();
      run_txn(0, $urandom, '0, rb, 2, -1, 1, 1, 3, 0);
      checks++; if (o_rsp_cyc != 4 || o_rsp_unstable != 0) begin failures++;
         $display("FAIL rsp_hold got=cycles%0d/unstable%0d exp=4/0", o_rsp_cyc, o_rsp_unstable); end
      checks++; if (o_req_ready_bad != 0) begin failures++; $display("FAIL rsp_req_ready_busy got=%0d exp=0", o_req_ready_bad); end
      checks++; if (o_rdata !== exp_line) begin failures++; $display("FAIL rsp_rdata got=%h exp=%h", o_rdata, exp_line); end
   endtask

   task automatic test_burst_len();
      logic [DW-1:0] rb [16];
      int nb [2] = '{1, 3};
      for (int k = 0; k < 2; k++) begin
         foreach (rb[i]) rb[i] = rnd_beat();
         run_txn(0, $urandom, '0, rb, nb[k], -1, 0, 1, 0, 0);
         checks++; if (o_timeout) begin failures++; $display("FAIL burst%0d_timeout got=1 exp=0", nb[k]); end
         checks++; if (o_rdata !== exp_line) begin failures++; $display("FAIL burst%0d_rdata got=%h exp=%h", nb[k], o_rdata, exp_line); end
         checks++; if (o_err !== exp_err) begin failures++; $display("FAIL burst%0d_err got=%b exp=%b", nb[k], o_err, exp_err); end
      end
   endtask

   task automatic test_err();
      logic [DW-1:0] rb [16];
      foreach (rb[i]) rb[i] = rnd_beat();
      run_txn(0, $urandom, '0, rb, 2, 1, 0, 1, 0, 0);
      checks++; if (o_err !== exp_err) begin failures++; $display("FAIL err_rresp got=%b exp=%b", o_err, exp_err); end
      foreach (rb[i]) rb[i] = rnd_beat();
      run_txn(0, $urandom, '0, rb, 2, -1, 0, 1, 0, 0);
      checks++; if (o_err !== exp_err) begin failures++; $display("FAIL err_clean_refill got=%b exp=%b", o_err, exp_err); end
      run_txn(1, $urandom, {16{32'($urandom)}}, rb, 0, -1, 0, 2, 0, 1);
      checks++; if (o_err !== exp_err) begin failures++; $display("FAIL err_bresp got=%b exp=%b", o_err, exp_err); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] rb [16];
      for (int k = 0; k < 3; k++) begin
         foreach (rb[i]) rb[i] = rnd_beat();
         run_txn(k[0], $urandom, {16{32'($urandom)}}, rb, 2, -1, 0, 1, 0, 0);
         checks++; if (o_timeout || !o_b2b_ok) begin failures++;
            $display("FAIL b2b%0d_ready_after_rsp got=to%b/ready%b exp=0/1", k, o_timeout, o_b2b_ok); end
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] rb [16];
      logic [LW-1:0] line;
      logic [31:0] a;
      bit we;
      int bad;
      for (int k = 0; k < 24; k++) begin
         foreach (rb[i]) rb[i] = rnd_beat();
         line = {rnd_beat(), rnd_beat()};
         a = $urandom; we = $urandom_range(0, 1);
         bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : -1;
         run_txn(we, a, line, rb, 2, bad, $urandom_range(0, 3), $urandom_range(1, 3),
                 $urandom_range(0, 2), $urandom_range(0, 5) == 0);
         checks++; if (o_timeout || o_addr !== line_base(a)) begin failures++;
            $display("FAIL rnd%0d_addr got=%h to=%b exp=%h", k, o_addr, o_timeout, line_base(a)); end
         checks++; if (o_rdata !== exp_line || o_err !== exp_err) begin failures++;
            $display("FAIL rnd%0d_rsp got=%h/%b exp=%h/%b", k, o_rdata, o_err, exp_line, exp_err); end
         if (we) begin
            checks++; if (o_wbeats.size() != 2 || o_wdata_bad != 0 || o_w_early != 0 || o_b_hs != 1) begin failures++;
               $display("FAIL rnd%0d_w got=beats%0d/bad%0d/early%0d/b%0d exp=2/0/0/1", k, o_wbeats.size(), o_wdata_bad, o_w_early, o_b_hs); end
         end
      end
   endtask

   task automatic test_reset_midburst();
      logic [DW-1:0] rb [16];
      logic [LW-1:0] line;
      int n = 0, stray = 0;
      foreach (rb[i]) rb[i] = '0;
      line = {rnd_beat(), rnd_beat()};
      @(negedge clk_i);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1234_5678; req_wdata = line;
      while (!req_ready && n < 50) begin @(negedge clk_i); n++; end
      @(negedge clk_i);
      req_valid = 1'b0;
      checks++; if (awvalid !== 1'b1) begin failures++; $display("FAIL midrst_awvalid got=%b exp=1", awvalid); end
      awready = 1'b1;
      @(negedge clk_i);
      awready = 1'b0; wready = 1'b0;
      checks++; if (wvalid !== 1'b1 || wdata !== line[DW-1:0]) begin failures++;
         $display("FAIL midrst_w_beat0 got=%b/%h exp=1/%h", wvalid, wdata, line[DW-1:0]); end
      #2 rst_i = 1'b0;
      #1;
      checks++; if ({arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err, req_ready} !== 8'b0000_0001) begin failures++;
         $display("FAIL midrst_async got=%b exp=00000001", {arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_err, req_ready}); end
      @(negedge clk_i);
      rst_i = 1'b1;
      exp_line = '0; exp_err = 1'b0;
      repeat (3) begin @(negedge clk_i); if (awvalid || wvalid || rsp_valid || !req_ready) stray++; end
      checks++; if (stray != 0) begin failures++; $display("FAIL midrst_no_resume got=%0d exp=0", stray); end
      line = {rnd_beat(), rnd_beat()};
      run_txn(1, 32'h0000_1000, line, rb, 0, -1, 0, 1, 0, 0);
      checks++; if (o_timeout || !o_first_ok || o_addr !== 32'h0000_1000) begin failures++;
         $display("FAIL midrst_restart got=to%b/first%b/%h exp=0/1/00001000", o_timeout, o_first_ok, o_addr); end
      checks++; if (o_wbeats.size() != 2 || o_wdata_bad != 0 || o_rdata !== exp_line) begin failures++;
         $display("FAIL midrst_restart_data got=beats%0d/bad%0d/%h exp=2/0/%h", o_wbeats.size(), o_wdata_bad, o_rdata, exp_line); end
   endtask

   initial begin
      req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
      arready = 0; awready = 0; wready = 0; rvalid = 0; rdata = '0; rresp = '0; rid = '0; rlast = 0;
      bvalid = 0; bresp = '0; bid = '0;
      test_reset();
      test_refill();
      test_writeback();
      test_ar_stall();
      test_rsp_backpressure();
      test_burst_len();
      test_err();
      test_back_to_back();
      test_random();
      test_reset_midburst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/axi_line_master.md
AXI_LINE_MASTER -- requirements
Module: axi_line_master

Interface
REQ-001 Parameter ADDR_WTH, 32, AXI/request address width.
REQ-002 Parameter DATA_WTH, 256, AXI data width; power of two, 64..1024.
REQ-003 Parameter ID_WIDTH, 4, AXI ID width.
REQ-004 Parameter LINE_BEATS, 2, beats per cache line; power of two, 1..16.
REQ-005 Parameter AXI_ID, 0, constant value driven on arid/awid.
REQ-006 The port clk_i SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-007 The port rst_i SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-008 req_valid in 1 / req_ready out 1 SHALL form the line-request handshake.
REQ-009 req_we in 1 (1=writeback, 0=refill); req_addr in ADDR_WTH; req_wdata in LINE_BEATS*DATA_WTH (beat 0 at LSBs).
REQ-010 rsp_valid out 1 / rsp_ready in 1 SHALL form the completion handshake; rsp_rdata out LINE_BEATS*DATA_WTH; rsp_err out 1.
REQ-011 AR out: araddr ADDR_WTH, arlen 8, arsize 3, arburst 2, arid ID_WIDTH, arcache 4, arlock 1, arprot 3, arqos 4, arregion 4, arvalid 1; in: arready 1.
REQ-012 R in: rdata DATA_WTH, rresp 2, rid ID_WIDTH, rlast 1, rvalid 1; out: rready 1.
REQ-013 AW out: same field set as AR with aw prefix; in: awready 1.
REQ-014 W out: wdata DATA_WTH, wstrb DATA_WTH/8, wlast 1, wvalid 1; in: wready 1. B in: bresp 2, bid ID_WIDTH, bvalid 1; out: bready 1.

Function
REQ-015 FSM states SHALL be IDLE, AR, R, AW, W, B, RSP; at most one transaction outstanding.
REQ-016 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready it SHALL latch addr, we and wdata, and go to AW if req_we else AR.
REQ-017 Latched address SHALL have its low log2(LINE_BEATS*DATA_WTH/8) bits forced to 0.
REQ-018 arvalid/awvalid SHALL assert the cycle after acceptance and hold with stable fields until arready/awready.
REQ-019 Constant fields: arlen/awlen=LINE_BEATS-1, arsize/awsize=log2(DATA_WTH/8), burst=2'b01, id=AXI_ID; cache, lock, prot, qos, region SHALL be 0.
REQ-020 R state: rready=1; beat counter starts at 0; each rvalid&&rready stores rdata to line slot [counter] and increments the counter.
REQ-021 Beats with counter >= LINE_BEATS SHALL be discarded, with no write beyond the buffer.
REQ-022 rvalid&&rready&&rlast SHALL end R and enter RSP in the next cycle, whether or not the counter has reached LINE_BEATS.
REQ-023 AW handshake -> W; wvalid=1, wstrb all ones, wdata=line slot [counter], wlast=(counter==LINE_BEATS-1).
REQ-024 In W, the counter and wdata SHALL advance only on wvalid&&wready; the last beat's handshake -> B.
REQ-025 B state: bready=1; bvalid -> RSP.
REQ-026 RSP: rsp_valid=1 and rsp_rdata stable until rsp_ready, then IDLE; rsp_rdata holds the refill line for reads and is unchanged for writes.
REQ-027 No AW/W overlap: wvalid SHALL never assert before the AW handshake completes.
REQ-028 Back-to-back: a request SHALL be acceptable in the cycle after RSP handshake (IDLE), with no other idle cycle.

Reset
REQ-029 Asserting rst_i low SHALL force IDLE, counter 0, and arvalid=awvalid=wvalid=rready=bready=rsp_valid=rsp_err=0 immediately, independent of clk_i.
REQ-030 After reset, req_ready SHALL be 1; line buffer and address registers SHALL reset to 0.
REQ-031 Reset mid-burst SHALL abandon the transaction; no resume and no rsp.

Configuration
REQ-032 Macro AXI_LINE_MASTER_ERR_CHK_EN defined: rsp_err is latched to 1 when any of the following occurs: rresp!=0 on any beat; bresp!=0; rid/bid != AXI_ID; rlast on a beat != LINE_BEATS-1; or a beat arrives with counter >= LINE_BEATS.
REQ-033 rsp_err SHALL clear on entry to AR/AW.
REQ-034 With the macro undefined, rsp_err SHALL be tied 0 and the checks SHALL be absent; FSM behaviour is otherwise identical.

Verification
REQ-035 Refill at req_addr=0x8000_0044, slave returns beats 0xA..,0xB.. -> araddr=0x8000_0040, arlen=1, arsize=5, arburst=1; rsp_rdata={0xB..,0xA..}; rsp_err=0.
REQ-036 Writeback at 0x8020_0000 with line {0x22..,0x11..}, wready asserted every 4th cycle -> awaddr=0x8020_0000; two W beats, wlast on the 2nd only; wstrb all ones; then B; rsp_valid.
REQ-037 Slave holds arready=0 for 5 cycles -> arvalid and araddr stable for all 6 cycles; exactly one AR handshake.
REQ-038 With ERR_CHK_EN, rresp=2 on beat 1 -> rsp_err=1; the next clean refill -> rsp_err=0.
REQ-039 rst_i low during W beat 0 -> all valids 0 in the same cycle; the next request starts cleanly with AW.
REQ-040 rsp_ready held low for 3 cycles -> rsp_valid and rsp_rdata stable; req_ready=0 until the rsp handshake completes.
